// File: rtl/rr_sel_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the round-robin select sequencer.
`default_nettype none

package sel_pkg;

  localparam int N_CH  = 4;
  localparam int IDX_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_CH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_sel_sequencer_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo N_CH.
`default_nettype none

module rr_pick
  import sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Offset N_CH wraps back to 'last' itself, so a lone requester can be re-picked.
  always_comb begin
    any   = |req;
    idx   = last;
    cand  = last;
    found = 1'b0;
    for (int j = 1; j <= N_CH; j++) begin
      cand = last + IDX_W'(j);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_sel_sequencer.sv
// Round-robin arbiter driving mux4to1 selects with a valid/ack handshake and grant timeout.
`default_nettype none

module rr_sel_sequencer
  import sel_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CW      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic            ack,
  output logic            s0,
  output logic            s1,
  output logic            valid,
  output logic [N_CH-1:0] grant,
  output logic            timeout
);

  localparam logic [CW-1:0] EXP_CNT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last;
  logic [CW-1:0]    hold_cnt;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] pick_last;
  logic             expire;
  logic             release_grant;

  // Any exit from GRANT sets last=idx, so the picker can use idx directly there.
  assign pick_last     = (state == ST_GRANT) ? idx : last;
  assign expire        = (TIMEOUT != 0) && (hold_cnt == EXP_CNT);
  assign release_grant = ack || !req[idx] || expire;

  rr_pick u_pick (
    .req  (req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      last     <= IDX_W'(N_CH - 1);
      hold_cnt <= '0;
      valid    <= 1'b0;
      grant    <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            idx      <= pick_idx;
            hold_cnt <= '0;
            valid    <= 1'b1;
            grant    <= onehot(pick_idx);
          end
        end
        default: begin
          if (release_grant) begin
            last     <= idx;
            hold_cnt <= '0;
            // Timeout only fires when neither ack nor a request drop claimed the cycle.
            timeout  <= expire && !ack && req[idx];
            if (pick_any) begin
              idx   <= pick_idx;
              valid <= 1'b1;
              grant <= onehot(pick_idx);
            end else begin
              state <= ST_IDLE;
              valid <= 1'b0;
              grant <= '0;
            end
          end else if (hold_cnt != {CW{1'b1}}) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign s1 = idx[1];
  assign s0 = idx[0];

endmodule

`default_nettype wire

// File: tb/tb_rr_sel_sequencer.sv
// Directed self-checking bench for rr_sel_sequencer with a behavioural mux4to1 on its selects.
`default_nettype none

module tb_rr_sel_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       ack;
  logic       s0, s1, valid, timeout;
  logic [3:0] grant;
  logic [3:0] i0, i1, i2, i3, y;

  int n_checks;
  int n_fail;

  rr_sel_sequencer #(.TIMEOUT(8), .CW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .ack     (ack),
    .s0      (s0),
    .s1      (s1),
    .valid   (valid),
    .grant   (grant),
    .timeout (timeout)
  );

  always_comb begin
    case ({s1, s0})
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic v, input logic [3:0] g,
                           input logic [1:0] sel, input logic to);
    chk({tag, ".valid"},   32'(valid),      32'(v));
    chk({tag, ".grant"},   32'(grant),      32'(g));
    chk({tag, ".sel"},     32'({s1, s0}),   32'(sel));
    chk({tag, ".timeout"}, 32'(timeout),    32'(to));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i0 = 4'd1; i1 = 4'd2; i2 = 4'd2; i3 = 4'd3;
    reset = 1'b1;
    req   = 4'b1111;
    ack   = 1'b0;

    // Reset held with all requests active
    step();
    step();
    chk_grant("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    step();
    chk_grant("first_pick", 1'b1, 4'b0001, 2'd0, 1'b0);
    chk("y_ch0", 32'(y), 32'd1);

    // Back-to-back acks rotate through all channels without a bubble
    ack = 1'b1;
    step(); chk_grant("rr1", 1'b1, 4'b0010, 2'd1, 1'b0); chk("y_ch1", 32'(y), 32'd2);
    step(); chk_grant("rr2", 1'b1, 4'b0100, 2'd2, 1'b0); chk("y_ch2", 32'(y), 32'd2);
    step(); chk_grant("rr3", 1'b1, 4'b1000, 2'd3, 1'b0); chk("y_ch3", 32'(y), 32'd3);
    step(); chk_grant("rr0", 1'b1, 4'b0001, 2'd0, 1'b0); chk("y_ch0b", 32'(y), 32'd1);

    // Drop req[0] without ack: abandon and move to channel 2
    ack = 1'b0;
    req = 4'b0100;
    step(); chk_grant("drop_to2", 1'b1, 4'b0100, 2'd2, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step(); chk_grant("hold2", 1'b1, 4'b0100, 2'd2, 1'b0);
    end
    step(); chk_grant("timeout2", 1'b1, 4'b0100, 2'd2, 1'b1);
    // Re-grant restarts the hold count: next pulse exactly 8 cycles later
    for (int c = 0; c < 7; c++) begin
      step(); chk_grant("rehold2", 1'b1, 4'b0100, 2'd2, 1'b0);
    end
    step(); chk_grant("timeout2b", 1'b1, 4'b0100, 2'd2, 1'b1);

    // Move to channel 0, then ack it so last=0 with req=1001
    req = 4'b0001;
    step(); chk_grant("to_ch0", 1'b1, 4'b0001, 2'd0, 1'b0);
    req = 4'b1001;
    ack = 1'b1;
    step(); chk_grant("to_ch3", 1'b1, 4'b1000, 2'd3, 1'b0);
    ack = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step(); chk_grant("hold3", 1'b1, 4'b1000, 2'd3, 1'b0);
    end
    // ack on the expiry cycle suppresses the timeout
    ack = 1'b1;
    step(); chk_grant("ack_expiry", 1'b1, 4'b0001, 2'd0, 1'b0);

    // Channel 1 granted, then its request drops
    req = 4'b0010;
    step(); chk_grant("to_ch1", 1'b1, 4'b0010, 2'd1, 1'b0);
    ack = 1'b0;
    req = 4'b0100;
    step(); chk_grant("drop1_to2", 1'b1, 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    step(); chk_grant("drop_idle", 1'b0, 4'b0000, 2'd2, 1'b0);
    ack = 1'b1;
    step(); chk_grant("ack_idle", 1'b0, 4'b0000, 2'd2, 1'b0);

    // From idle with last=2, channel 3 wins; a lone requester is re-granted
    ack = 1'b0;
    req = 4'b1000;
    step(); chk_grant("idle_to3", 1'b1, 4'b1000, 2'd3, 1'b0);
    ack = 1'b1;
    step(); chk_grant("regrant3", 1'b1, 4'b1000, 2'd3, 1'b0);

    // Asynchronous reset mid-grant clears outputs without a clock edge
    ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(valid), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_sel",   32'({s1, s0}), 32'd0);
    step();
    reset = 1'b0;
    req   = 4'b0000;
    step(); chk_grant("post_reset_idle", 1'b0, 4'b0000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
